pipeline_pc_gen: RTL and testbench
==================================

# pipeline_pc_gen

Parametrised program-counter generator for the pipelined CPU fetch stage. It selects the next PC from sequential, conditional-branch, jump, register-jump and exception sources. It preserves the supervisor bit (PC MSB) on sequential fetch. A DEPTH-entry return-address stack (RAS) pushes link addresses on calls and checks register-jump returns against the predicted value.

## Interface
- XLEN, 32: PC width; bit XLEN-1 is the supervisor bit.
- RESET_VEC, 32'h8000_0000: PC after reset.
- ILLOP_VEC, 32'h8000_0004: illegal-op / interrupt vector.
- XADR_VEC, 32'h8000_0008: exception vector.
- RAS_DEPTH, 4: RAS entries, power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- stall  in  1  hold the sequential/not-taken path.
- pc_src  in  3  next-PC select (see Operation).
- br_taken  in  1  branch condition (ALU result bit 0).
- con_ba  in  XLEN  branch target.
- jt  in  26  jump-target field.
- jr_target  in  XLEN  register-jump target (register file port A).
- is_call  in  1  with pc_src=010 or 011: push link address.
- is_ret  in  1  with pc_src=011: pop and check.
- pc  out  XLEN  current PC, registered.
- pc_plus4  out  XLEN  {pc[XLEN-1], pc[XLEN-2:0]+4}, combinational.
- ras_top  out  XLEN  top RAS entry; 0 when empty.
- ras_count  out  clog2(RAS_DEPTH)+1  valid entries.
- ras_mispredict  out  1  registered one-cycle pulse.

## Operation
- Sequential value seq = stall ? pc : pc_plus4. The increment wraps within bits XLEN-2:0 and never changes the supervisor bit.
- pc_src decode, evaluated each edge:
  - 000: pc <= seq.
  - 001: pc <= br_taken ? con_ba : seq.
  - 010: pc <= {pc[XLEN-1:28], jt, 2'b00}.
  - 011: pc <= jr_target, used unmodified.
  - 100: pc <= ILLOP_VEC.
  - 101: pc <= XADR_VEC.
  - 110, 111: pc holds; no RAS activity.
- stall affects only the seq path. Taken branches, jumps, register-jumps and vectors load regardless of stall.
- RAS is a circular buffer with write pointer wp and count cnt.
  - Push (is_call & pc_src∈{010,011}): entry[wp] <= pc_plus4; wp++ mod RAS_DEPTH; cnt <= min(cnt+1, RAS_DEPTH). A push when full overwrites the oldest entry.
  - Pop (is_ret & pc_src=011): if cnt>0, wp--, cnt--, and ras_mispredict <= (entry[wp-1] != jr_target). If cnt=0, ras_mispredict <= 1 and state is unchanged.
  - Push and pop in the same cycle (is_call & is_ret, pc_src=011): compare against the current top, then replace it with pc_plus4; wp and cnt unchanged. If empty, this is a push, and ras_mispredict <= 1.
  - is_call/is_ret with any other pc_src: ignored.
- ras_top = entry[wp-1] when cnt>0, else 0.
- Vector loads (100/101) do not alter the RAS.

## Timing
- Reset values (asynchronous, held while reset=0): pc=RESET_VEC, wp=0, cnt=0, ras_mispredict=0, ras_top=0. RAS entry contents are don't-care.
- Reset deasserted mid-operation: the first rising edge after release evaluates pc_src normally from RESET_VEC.
- Next PC latency: 1 cycle from the pc_src/target inputs to the pc output.
- pc_plus4 and ras_top follow pc/RAS state combinationally in the same cycle.
- ras_mispredict is asserted in the cycle after the pop edge and lasts exactly 1 cycle unless another mispredicting pop follows.
- No handshakes; the upstream decoder holds pc_src valid for one cycle per instruction.

## Test plan
- Reset: assert reset=0 mid-cycle -> pc=32'h8000_0000 immediately, ras_count=0. Release with pc_src=000, stall=0 for 3 edges -> pc 8000_0004, 8000_0008, 8000_000C.
- Supervisor wrap: force pc=32'hFFFF_FFFC via jr, then pc_src=000 -> pc=32'h8000_0000. From pc=32'h7FFF_FFFC -> pc=0.
- Stall vs redirect: stall=1 with pc_src=000 -> pc holds. stall=1 with pc_src=001, br_taken=0 -> holds. stall=1 with pc_src=001, br_taken=1, con_ba=32'h0000_0040 -> pc=0x40. stall=1 with pc_src=101 -> pc=32'h8000_0008.
- Jump: pc=32'h8000_0100, pc_src=010, jt=26'h0000010, is_call=1 -> pc=32'h8000_0040, ras_top=32'h8000_0104. Then jr to 32'h8000_0104 with is_ret=1 -> ras_mispredict=0, ras_count=0.
- RAS overflow/underflow (RAS_DEPTH=4): 5 calls from PCs A..E -> ras_count=4, pops return E+4, D+4, C+4, B+4. A 5th pop on empty -> ras_mispredict=1, count stays 0.
- Mismatch and simultaneous push/pop: with top=X+4, pop with jr_target≠X+4 -> 1-cycle ras_mispredict pulse. is_call&is_ret at pc=Y -> mispredict compared against the old top, ras_top=Y+4, count unchanged.

Source files
------------

// File: rtl/pipeline_pc_gen.sv
// Fetch-stage program-counter generator: next-PC selection with a supervisor-preserving
// sequential path and a circular return-address stack that checks predicted returns.
module pipeline_pc_gen #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = 32'h8000_0000,
    parameter logic [XLEN-1:0]  ILLOP_VEC = 32'h8000_0004,
    parameter logic [XLEN-1:0]  XADR_VEC  = 32'h8000_0008,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic [2:0]                pc_src,
    input  logic                      br_taken,
    input  logic [XLEN-1:0]           con_ba,
    input  logic [25:0]               jt,
    input  logic [XLEN-1:0]           jr_target,
    input  logic                      is_call,
    input  logic                      is_ret,
    output logic [XLEN-1:0]           pc,
    output logic [XLEN-1:0]           pc_plus4,
    output logic [XLEN-1:0]           ras_top,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                      ras_mispredict
);

    localparam int unsigned AW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        SRC_SEQ   = 3'b000,
        SRC_BR    = 3'b001,
        SRC_JMP   = 3'b010,
        SRC_JR    = 3'b011,
        SRC_ILLOP = 3'b100,
        SRC_XADR  = 3'b101,
        SRC_HOLD0 = 3'b110,
        SRC_HOLD1 = 3'b111
    } pc_src_e;

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   wp_nxt;
    logic [AW-1:0]   top_idx;
    logic [AW-1:0]   mem_waddr;
    logic [CW-1:0]   cnt_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] seq_pc;
    logic            mp_nxt;
    logic            mem_we;
    logic            do_push;
    logic            do_pop;
    logic            ras_empty;

    // Increment wraps inside the low bits so the supervisor bit is never disturbed.
    assign pc_plus4  = {pc[XLEN-1], pc[XLEN-2:0] + (XLEN-1)'(4)};
    assign seq_pc    = stall ? pc : pc_plus4;
    assign top_idx   = wp - AW'(1);
    assign ras_empty = (ras_count == '0);
    assign ras_top   = ras_empty ? '0 : ras_mem[top_idx];
    assign do_push   = is_call & ((pc_src == SRC_JMP) | (pc_src == SRC_JR));
    assign do_pop    = is_ret & (pc_src == SRC_JR);

    // Next-PC select
    always_comb begin
        pc_nxt = pc;
        case (pc_src_e'(pc_src))
            SRC_SEQ:   pc_nxt = seq_pc;
            SRC_BR:    pc_nxt = br_taken ? con_ba : seq_pc;
            SRC_JMP:   pc_nxt = {pc[XLEN-1:28], jt, 2'b00};
            SRC_JR:    pc_nxt = jr_target;
            SRC_ILLOP: pc_nxt = ILLOP_VEC;
            SRC_XADR:  pc_nxt = XADR_VEC;
            default:   pc_nxt = pc;
        endcase
    end

    // RAS next state; a simultaneous call/return on a non-empty stack replaces the top in place.
    always_comb begin
        wp_nxt    = wp;
        cnt_nxt   = ras_count;
        mp_nxt    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wp;
        if (do_push && do_pop && !ras_empty) begin
            mp_nxt    = (ras_top != jr_target);
            mem_we    = 1'b1;
            mem_waddr = top_idx;
        end else if (do_push) begin
            mem_we = 1'b1;
            wp_nxt = wp + AW'(1);
            mp_nxt = do_pop;
            if (ras_count != CW'(RAS_DEPTH)) begin
                cnt_nxt = ras_count + CW'(1);
            end
        end else if (do_pop) begin
            if (ras_empty) begin
                mp_nxt = 1'b1;
            end else begin
                mp_nxt  = (ras_top != jr_target);
                wp_nxt  = top_idx;
                cnt_nxt = ras_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc             <= RESET_VEC;
            wp             <= '0;
            ras_count      <= '0;
            ras_mispredict <= 1'b0;
        end else begin
            pc             <= pc_nxt;
            wp             <= wp_nxt;
            ras_count      <= cnt_nxt;
            ras_mispredict <= mp_nxt;
        end
    end

    // Entry contents need no reset; validity is tracked by ras_count.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            ras_mem[mem_waddr] <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_pipeline_pc_gen.sv
// Self-checking bench for pipeline_pc_gen: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_pipeline_pc_gen;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_src;
    logic        br_taken;
    logic [31:0] con_ba;
    logic [25:0] jt;
    logic [31:0] jr_target;
    logic        is_call;
    logic        is_ret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ras_top;
    logic [2:0]  ras_count;
    logic        ras_mispredict;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_mp;

    pipeline_pc_gen #(.XLEN(32), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src), .br_taken(br_taken),
        .con_ba(con_ba), .jt(jt), .jr_target(jr_target), .is_call(is_call), .is_ret(is_ret),
        .pc(pc), .pc_plus4(pc_plus4), .ras_top(ras_top), .ras_count(ras_count),
        .ras_mispredict(ras_mispredict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] inc4(input logic [31:0] v);
        return (v & 32'h8000_0000) | ((v + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    function automatic logic [31:0] model_top();
        return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".pc"},       pc,                m_pc);
        check({tag, ".pc4"},      pc_plus4,          inc4(m_pc));
        check({tag, ".top"},      ras_top,           model_top());
        check({tag, ".cnt"},      32'(ras_count),    32'(m_ras.size()));
        check({tag, ".mp"},       32'(ras_mispredict), 32'(m_mp));
    endtask

    // Apply one instruction's worth of inputs, advance one edge, then compare.
    task automatic step(input string tag, input logic st, input logic [2:0] src, input logic bt,
                        input logic [31:0] cba, input logic [25:0] j, input logic [31:0] jrt,
                        input logic call, input logic ret);
        logic [31:0] seq;
        logic [31:0] nxt;
        logic [31:0] link;
        logic        push;
        logic        pop;
        stall = st; pc_src = src; br_taken = bt; con_ba = cba; jt = j;
        jr_target = jrt; is_call = call; is_ret = ret;
        seq  = st ? m_pc : inc4(m_pc);
        link = inc4(m_pc);
        case (src)
            3'd0:    nxt = seq;
            3'd1:    nxt = bt ? cba : seq;
            3'd2:    nxt = {m_pc[31:28], j, 2'b00};
            3'd3:    nxt = jrt;
            3'd4:    nxt = ILLOP_VEC;
            3'd5:    nxt = XADR_VEC;
            default: nxt = m_pc;
        endcase
        push = call && (src == 3'd2 || src == 3'd3);
        pop  = ret && (src == 3'd3);
        m_mp = 1'b0;
        if (push && pop) begin
            if (m_ras.size() > 0) begin
                m_mp = (model_top() != jrt);
                m_ras[m_ras.size()-1] = link;
            end else begin
                m_mp = 1'b1;
                m_ras.push_back(link);
            end
        end else if (push) begin
            m_ras.push_back(link);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (pop) begin
            if (m_ras.size() > 0) begin
                m_mp = (model_top() != jrt);
                void'(m_ras.pop_back());
            end else begin
                m_mp = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_pc = nxt;
        check_all(tag);
    endtask

    task automatic seq_step(input string tag);
        step(tag, 1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic jr(input string tag, input logic [31:0] t, input logic call, input logic ret);
        step(tag, 1'b0, 3'd3, 1'b0, 32'h0, 26'h0, t, call, ret);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        m_pc = RESET_VEC;
        m_ras.delete();
        m_mp = 1'b0;
        check("rst.pc", pc, RESET_VEC);
        check("rst.cnt", 32'(ras_count), 32'h0);
        check("rst.top", ras_top, 32'h0);
        check("rst.mp", 32'(ras_mispredict), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] tgt;
        logic [2:0]  src;
        reset = 1'b0; stall = 1'b0; pc_src = 3'd0; br_taken = 1'b0; con_ba = '0;
        jt = '0; jr_target = '0; is_call = 1'b0; is_ret = 1'b0;
        m_pc = RESET_VEC; m_mp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Run a little, then reset mid-cycle and check the release sequence.
        seq_step("warm");
        jr("warm.call", 32'h0000_1230, 1'b1, 1'b0);
        apply_reset();
        seq_step("rel0");
        check("rel0.const", pc, 32'h8000_0004);
        seq_step("rel1");
        seq_step("rel2");
        check("rel2.const", pc, 32'h8000_000C);

        // Jump with call, then matching return.
        jr("j.set", 32'h8000_0100, 1'b0, 1'b0);
        step("j.call", 1'b0, 3'd2, 1'b0, 32'h0, 26'h0000010, 32'h0, 1'b1, 1'b0);
        check("j.pc.const", pc, 32'h8000_0040);
        check("j.top.const", ras_top, 32'h8000_0104);
        jr("j.ret", 32'h8000_0104, 1'b0, 1'b1);
        check("j.ret.mp.const", 32'(ras_mispredict), 32'h0);

        // Supervisor bit preserved across the increment wrap.
        jr("w.set1", 32'hFFFF_FFFC, 1'b0, 1'b0);
        seq_step("w.seq1");
        check("w.seq1.const", pc, 32'h8000_0000);
        jr("w.set2", 32'h7FFF_FFFC, 1'b0, 1'b0);
        seq_step("w.seq2");
        check("w.seq2.const", pc, 32'h0000_0000);

        // Stall only affects the sequential path.
        jr("s.set", 32'h0000_0200, 1'b0, 1'b0);
        step("s.seq", 1'b1, 3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        step("s.nt", 1'b1, 3'd1, 1'b0, 32'h40, 26'h0, 32'h0, 1'b0, 1'b0);
        step("s.tk", 1'b1, 3'd1, 1'b1, 32'h40, 26'h0, 32'h0, 1'b0, 1'b0);
        check("s.tk.const", pc, 32'h0000_0040);
        step("s.xadr", 1'b1, 3'd5, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        step("s.illop", 1'b0, 3'd4, 1'b0, 32'h0, 26'h0, 32'h0, 1'b1, 1'b1);
        step("s.hold", 1'b0, 3'd6, 1'b0, 32'h0, 26'h0, 32'h0, 1'b1, 1'b1);

        // Overflow: five calls from A..E, four pops, then an underflow pop.
        jr("o.A", 32'h0000_1000, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) jr("o.call", 32'h0000_1000 * (i + 1), 1'b1, 1'b0);
        check("o.cnt.const", 32'(ras_count), 32'd4);
        for (int i = 5; i >= 2; i--) jr("o.pop", 32'h0000_1000 * i + 32'd4, 1'b0, 1'b1);
        jr("o.under", 32'h0000_1004, 1'b0, 1'b1);
        check("o.under.mp.const", 32'(ras_mispredict), 32'h1);
        seq_step("o.after");

        // Mispredicted return pulse, then simultaneous call/return.
        jr("m.call", 32'h0000_3000, 1'b1, 1'b0);
        jr("m.badret", 32'h0000_3333, 1'b0, 1'b1);
        seq_step("m.pulse_end");
        jr("m.call2", 32'h0000_4000, 1'b1, 1'b0);
        jr("m.both", 32'h0000_5000, 1'b1, 1'b1);
        check("m.both.top.const", ras_top, 32'h0000_4004);
        jr("m.both_empty_pre", 32'h0000_5004, 1'b0, 1'b1);
        jr("m.both_empty", 32'h0000_6000, 1'b1, 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            src = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) src = 3'd3;
            tgt = $urandom;
            if ($urandom_range(0, 1) == 1 && m_ras.size() > 0) tgt = model_top();
            step("rnd", 1'($urandom_range(0, 1)), src, 1'($urandom_range(0, 1)), $urandom,
                 26'($urandom), tgt, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
